fifo_wr_arbiter: RTL

- Round-robin write arbiter that shares the write port of one 32-bit FIFO (wr_en/din/full) between N_REQ producers.
- Grants one producer at a time and holds the grant for a burst.
- A burst ends on the producer's last flag or after MAX_BURST accepted words.
- Sits directly in front of the FIFO write side; the FIFO read side is untouched.

---
 rtl/fifo_wr_arbiter.sv | 169 ++++++++++++++++
 1 files changed

// File: rtl/fifo_wr_arbiter.sv
// Purpose : round-robin arbiter sharing one FIFO write port between N_REQ producers, grant held per burst.
// Latency : one arbitration cycle in IDLE; then one word per cycle straight through (fifo_wr_en/din/req_ready combinational).
// Backpr. : fifo_full stalls the granted producer (req_ready low, no write, grant and beat count held).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   req_valid/last/data per-requester word valid, end-of-packet, packed data ([i*DW +: DW])
//   req_ready           per-requester accept (only the granted one can be high)
//   fifo_full           FIFO full flag
//   fifo_wr_en/fifo_din FIFO write enable and data of the granted requester
//   grant, busy         registered one-hot grant and GRANT-state flag
//   timeout_evt         one-cycle pulse on a forced release (only with FIFOARB_TIMEOUT_EN)
//
// Optional feature macro: FIFOARB_TIMEOUT_EN -- releases a grant whose owner has
// been idle (valid low, FIFO not full) for IDLE_TIMEOUT consecutive cycles.
module fifo_wr_arbiter #(
  parameter int N_REQ        = 4,
  parameter int DW           = 32,
  parameter int MAX_BURST    = 4,
  parameter int IDLE_TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_REQ-1:0]    req_valid,
  input  logic [N_REQ-1:0]    req_last,
  input  logic [N_REQ*DW-1:0] req_data,
  output logic [N_REQ-1:0]    req_ready,
  input  logic                fifo_full,
  output logic                fifo_wr_en,
  output logic [DW-1:0]       fifo_din,
  output logic [N_REQ-1:0]    grant,
  output logic                busy
`ifdef FIFOARB_TIMEOUT_EN
  ,
  output logic                timeout_evt
`endif
);

  localparam int IW = $clog2(N_REQ);
  localparam int BW = $clog2(MAX_BURST) + 1;

  if (N_REQ < 2 || N_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 16 || IDLE_TIMEOUT < 1) begin : g_param_check
    $error("fifo_wr_arbiter: parameter out of range");
  end

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t        state;
  logic [IW-1:0] grant_idx;
  logic [IW-1:0] rr_ptr;
  logic [BW-1:0] beat_cnt;

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping.
  // Offsets are scanned from the far end so the nearest hit is the last write.
  logic          any_req;
  logic [IW-1:0] winner;
  logic [IW:0]   cand_sum;

  always_comb begin
    any_req  = 1'b0;
    winner   = rr_ptr;
    cand_sum = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand_sum = {1'b0, rr_ptr} + (IW+1)'(k);
      if (cand_sum >= (IW+1)'(N_REQ)) begin
        cand_sum = cand_sum - (IW+1)'(N_REQ);
      end
      if (req_valid[cand_sum[IW-1:0]]) begin
        any_req = 1'b1;
        winner  = cand_sum[IW-1:0];
      end
    end
  end

  // Write path: only the granted requester reaches the FIFO.
  logic cur_valid;
  assign cur_valid  = req_valid[grant_idx];
  assign fifo_wr_en = (state == GRANT) & cur_valid & ~fifo_full;
  assign fifo_din   = req_data[int'(grant_idx)*DW +: DW];

  always_comb begin
    req_ready = '0;
    if (state == GRANT) begin
      req_ready[grant_idx] = ~fifo_full;
    end
  end

  // Burst end: last word of a packet, or the MAX_BURST-th word of this grant.
  logic          rel_beat;
  logic          release_now;
  logic [IW-1:0] next_ptr;

  assign rel_beat = fifo_wr_en & (req_last[grant_idx] | (beat_cnt == BW'(MAX_BURST - 1)));
  assign next_ptr = (grant_idx == IW'(N_REQ - 1)) ? '0 : grant_idx + 1'b1;

`ifdef FIFOARB_TIMEOUT_EN
  localparam int TW = $clog2(IDLE_TIMEOUT + 1);
  logic [TW-1:0] stall_cnt;
  logic          timeout_fire;

  // Fires on the IDLE_TIMEOUT-th consecutive cycle with the owner idle and room in the FIFO.
  assign timeout_fire = (state == GRANT) & ~fifo_full & ~cur_valid &
                        (stall_cnt == TW'(IDLE_TIMEOUT - 1));
  assign release_now  = rel_beat | timeout_fire;
`else
  assign release_now  = rel_beat;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      grant     <= '0;
      busy      <= 1'b0;
      grant_idx <= '0;
      rr_ptr    <= '0;
      beat_cnt  <= '0;
`ifdef FIFOARB_TIMEOUT_EN
      stall_cnt   <= '0;
      timeout_evt <= 1'b0;
`endif
    end else begin
`ifdef FIFOARB_TIMEOUT_EN
      timeout_evt <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (any_req) begin
            state     <= GRANT;
            grant     <= N_REQ'(1) << winner;
            grant_idx <= winner;
            busy      <= 1'b1;
            beat_cnt  <= '0;
          end
`ifdef FIFOARB_TIMEOUT_EN
          stall_cnt <= '0;
`endif
        end
        GRANT: begin
          if (release_now) begin
            state    <= IDLE;
            grant    <= '0;
            busy     <= 1'b0;
            rr_ptr   <= next_ptr;
            beat_cnt <= '0;
          end else if (fifo_wr_en) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
`ifdef FIFOARB_TIMEOUT_EN
          if (fifo_full || cur_valid || timeout_fire) begin
            stall_cnt <= '0;
          end else begin
            stall_cnt <= stall_cnt + 1'b1;
          end
          if (timeout_fire) begin
            timeout_evt <= 1'b1;
          end
`endif
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
